trap_ctrl: RTL and testbench

Machine-mode trap sequencer for the core. It detects exceptions (ecall, ebreak, illegal instruction), enabled interrupts (external, software, timer) and `mret`. It then drives the CSR file's trap channel through a fixed read-modify-write sequence (mepc, mcause, mtval, mstatus, mtvec) and finally issues a PC redirect. It sits between the idex stage, the CSR file's trap port and the fetch/PC logic, and stalls the pipeline while a sequence is in flight.

---
 rtl/trap_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Brief    : Machine-mode trap/mret sequencer driving the CSR trap channel.
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        illegal_i,
    input  logic        mret_i,
    input  logic        ex_trap_i,
    input  logic        soft_trap_i,
    input  logic        tcmp_trap_i,
    input  logic        mstatus_mie_i,
    input  logic [31:0] mepc_i,
    input  logic        idex_csr_we_i,
    input  logic [31:0] trap_csr_rdata_i,
    output logic        trap_csr_we_o,
    output logic [11:0] trap_csr_addr_o,
    output logic [31:0] trap_csr_wdata_o,
    output logic        hold_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_t_mepc    = 3'd1;
    localparam logic [2:0] c_st_t_mcause  = 3'd2;
    localparam logic [2:0] c_st_t_mtval   = 3'd3;
    localparam logic [2:0] c_st_t_mstatus = 3'd4;
    localparam logic [2:0] c_st_t_jump    = 3'd5;
    localparam logic [2:0] c_st_r_mstatus = 3'd6;
    localparam logic [2:0] c_st_r_jump    = 3'd7;

    localparam logic [11:0] c_addr_mstatus = 12'h300;
    localparam logic [11:0] c_addr_mtvec   = 12'h305;
    localparam logic [11:0] c_addr_mepc    = 12'h341;
    localparam logic [11:0] c_addr_mcause  = 12'h342;
    localparam logic [11:0] c_addr_mtval   = 12'h343;

    logic [2:0]  state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;

    logic        w_trap_acc;
    logic        w_mret_acc;
    logic [31:0] w_cause;

    // Event arbitration: exceptions, then mret, then enabled interrupts.
    always_comb begin
        w_trap_acc = 1'b0;
        w_mret_acc = 1'b0;
        w_cause    = 32'h0;
        if (inst_valid_i) begin
            if (illegal_i) begin
                w_trap_acc = 1'b1;
                w_cause    = 32'd2;
            end else if (ebreak_i) begin
                w_trap_acc = 1'b1;
                w_cause    = 32'd3;
            end else if (ecall_i) begin
                w_trap_acc = 1'b1;
                w_cause    = 32'd11;
            end else if (mret_i) begin
                w_mret_acc = 1'b1;
            end else if (mstatus_mie_i) begin
                if (ex_trap_i) begin
                    w_trap_acc = 1'b1;
                    w_cause    = 32'h8000_000B;
                end else if (soft_trap_i) begin
                    w_trap_acc = 1'b1;
                    w_cause    = 32'h8000_0003;
                end else if (tcmp_trap_i) begin
                    w_trap_acc = 1'b1;
                    w_cause    = 32'h8000_0007;
                end
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        cause_d          = cause_q;
        epc_d            = epc_q;
        tval_d           = tval_q;
        trap_csr_we_o    = 1'b0;
        trap_csr_addr_o  = 12'h0;
        trap_csr_wdata_o = 32'h0;
        hold_o           = (state_q != c_st_idle);
        jump_o           = 1'b0;
        jump_addr_o      = 32'h0;

        case (state_q)
            c_st_idle: begin
                hold_o = w_trap_acc | w_mret_acc;
                if (w_trap_acc) begin
                    state_d = c_st_t_mepc;
                    cause_d = w_cause;
                    epc_d   = pc_i;
                    tval_d  = illegal_i ? inst_i : 32'h0;
                end else if (w_mret_acc) begin
                    state_d = c_st_r_mstatus;
                end
            end
            c_st_t_mepc: begin
                if (!idex_csr_we_i) begin
                    trap_csr_we_o    = 1'b1;
                    trap_csr_addr_o  = c_addr_mepc;
                    trap_csr_wdata_o = epc_q;
                    state_d          = c_st_t_mcause;
                end
            end
            c_st_t_mcause: begin
                if (!idex_csr_we_i) begin
                    trap_csr_we_o    = 1'b1;
                    trap_csr_addr_o  = c_addr_mcause;
                    trap_csr_wdata_o = cause_q;
                    state_d          = c_st_t_mtval;
                end
            end
            c_st_t_mtval: begin
                if (!idex_csr_we_i) begin
                    trap_csr_we_o    = 1'b1;
                    trap_csr_addr_o  = c_addr_mtval;
                    trap_csr_wdata_o = tval_q;
                    state_d          = c_st_t_mstatus;
                end
            end
            c_st_t_mstatus: begin
                // Same-cycle RMW: MPIE <= MIE, MIE <= 0.
                if (!idex_csr_we_i) begin
                    trap_csr_we_o    = 1'b1;
                    trap_csr_addr_o  = c_addr_mstatus;
                    trap_csr_wdata_o = {trap_csr_rdata_i[31:8], trap_csr_rdata_i[3],
                                        trap_csr_rdata_i[6:4], 1'b0,
                                        trap_csr_rdata_i[2:0]};
                    state_d          = c_st_t_jump;
                end
            end
            c_st_t_jump: begin
                trap_csr_addr_o = c_addr_mtvec;
                jump_o          = 1'b1;
                jump_addr_o     = (trap_csr_rdata_i == 32'h0) ? RESET_VEC
                                : {trap_csr_rdata_i[31:2], 2'b00};
                state_d         = c_st_idle;
            end
            c_st_r_mstatus: begin
                // MIE <= MPIE, MPIE <= 1.
                if (!idex_csr_we_i) begin
                    trap_csr_we_o    = 1'b1;
                    trap_csr_addr_o  = c_addr_mstatus;
                    trap_csr_wdata_o = {trap_csr_rdata_i[31:8], 1'b1,
                                        trap_csr_rdata_i[6:4], trap_csr_rdata_i[7],
                                        trap_csr_rdata_i[2:0]};
                    state_d          = c_st_r_jump;
                end
            end
            c_st_r_jump: begin
                jump_o      = 1'b1;
                jump_addr_o = mepc_i;
                state_d     = c_st_idle;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase

        // A sequence cut short by reset must not finish its pending write or jump.
        if (rst) begin
            trap_csr_we_o    = 1'b0;
            trap_csr_addr_o  = 12'h0;
            trap_csr_wdata_o = 32'h0;
            hold_o           = 1'b0;
            jump_o           = 1'b0;
            jump_addr_o      = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_st_idle;
            cause_q <= 32'h0;
            epc_q   <= 32'h0;
            tval_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Brief    : Self-checking bench for trap_ctrl with a small CSR-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

    localparam logic [31:0] RV = 32'h0000_0400;
    localparam logic [31:0] SC = 32'hA5A5_0000;
    localparam logic [31:0] ST = 32'h5A5A_0000;
    localparam logic [6:0] F_ILL = 7'b1000000, F_EBR = 7'b0100000, F_ECL = 7'b0010000,
                           F_MRT = 7'b0001000, F_EXT = 7'b0000100, F_SFT = 7'b0000010,
                           F_TMR = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i;
    logic [31:0] pc_i, inst_i;
    logic        ecall_i, ebreak_i, illegal_i, mret_i;
    logic        ex_trap_i, soft_trap_i, tcmp_trap_i;
    logic        idex_csr_we_i;
    logic [31:0] trap_csr_rdata_i;
    logic        trap_csr_we_o;
    logic [11:0] trap_csr_addr_o;
    logic [31:0] trap_csr_wdata_o;
    logic        hold_o, jump_o;
    logic [31:0] jump_addr_o;

    logic [31:0] csr_mstatus, csr_mtvec, csr_mepc, csr_mcause, csr_mtval;
    logic        ld_en = 1'b0;
    logic [31:0] ld_ms, ld_tvec, ld_epc, ld_mc, ld_mt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.RESET_VEC(RV)) dut (
        .clk              (clk),
        .rst              (rst),
        .inst_valid_i     (inst_valid_i),
        .pc_i             (pc_i),
        .inst_i           (inst_i),
        .ecall_i          (ecall_i),
        .ebreak_i         (ebreak_i),
        .illegal_i        (illegal_i),
        .mret_i           (mret_i),
        .ex_trap_i        (ex_trap_i),
        .soft_trap_i      (soft_trap_i),
        .tcmp_trap_i      (tcmp_trap_i),
        .mstatus_mie_i    (csr_mstatus[3]),
        .mepc_i           (csr_mepc),
        .idex_csr_we_i    (idex_csr_we_i),
        .trap_csr_rdata_i (trap_csr_rdata_i),
        .trap_csr_we_o    (trap_csr_we_o),
        .trap_csr_addr_o  (trap_csr_addr_o),
        .trap_csr_wdata_o (trap_csr_wdata_o),
        .hold_o           (hold_o),
        .jump_o           (jump_o),
        .jump_addr_o      (jump_addr_o)
    );

    // CSR file stand-in: combinational read, write at the edge ending the write cycle.
    always_comb begin
        case (trap_csr_addr_o)
            12'h300: trap_csr_rdata_i = csr_mstatus;
            12'h305: trap_csr_rdata_i = csr_mtvec;
            12'h341: trap_csr_rdata_i = csr_mepc;
            12'h342: trap_csr_rdata_i = csr_mcause;
            12'h343: trap_csr_rdata_i = csr_mtval;
            default: trap_csr_rdata_i = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (ld_en) begin
            csr_mstatus <= ld_ms;
            csr_mtvec   <= ld_tvec;
            csr_mepc    <= ld_epc;
            csr_mcause  <= ld_mc;
            csr_mtval   <= ld_mt;
        end else if (trap_csr_we_o) begin
            case (trap_csr_addr_o)
                12'h300: csr_mstatus <= trap_csr_wdata_o;
                12'h305: csr_mtvec   <= trap_csr_wdata_o;
                12'h341: csr_mepc    <= trap_csr_wdata_o;
                12'h342: csr_mcause  <= trap_csr_wdata_o;
                12'h343: csr_mtval   <= trap_csr_wdata_o;
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        v;
        logic [6:0]  fl;
        logic [31:0] pc, inst, ms0, tvec0, epc0;
        logic [31:0] e_mepc, e_mcause, e_mtval, e_ms;
        int          e_jc;
        logic [31:0] e_ja;
        int          e_hold;
    } vec_t;

    function automatic vec_t mkv(logic v, logic [6:0] fl, logic [31:0] pc, logic [31:0] inst,
                                 logic [31:0] ms0, logic [31:0] tvec0, logic [31:0] epc0,
                                 logic [31:0] e_mepc, logic [31:0] e_mcause,
                                 logic [31:0] e_mtval, logic [31:0] e_ms, int e_jc,
                                 logic [31:0] e_ja, int e_hold);
        vec_t r;
        r.v = v; r.fl = fl; r.pc = pc; r.inst = inst; r.ms0 = ms0; r.tvec0 = tvec0;
        r.epc0 = epc0; r.e_mepc = e_mepc; r.e_mcause = e_mcause; r.e_mtval = e_mtval;
        r.e_ms = e_ms; r.e_jc = e_jc; r.e_ja = e_ja; r.e_hold = e_hold;
        return r;
    endfunction

    // Reference: final CSR contents and redirect outcome of one event.
    function automatic vec_t model(logic v, logic [6:0] fl, logic [31:0] pc, logic [31:0] inst,
                                   logic [31:0] ms, logic [31:0] tvec, logic [31:0] epc);
        vec_t        e;
        logic [31:0] cause = 32'h0;
        bit          trap = 0, ret = 0;
        e = mkv(v, fl, pc, inst, ms, tvec, epc, epc, SC, ST, ms, -1, 32'h0, 0);
        if (v) begin
            if (fl[6])      begin trap = 1; cause = 2;  end
            else if (fl[5]) begin trap = 1; cause = 3;  end
            else if (fl[4]) begin trap = 1; cause = 11; end
            else if (fl[3]) ret = 1;
            else if (ms[3]) begin
                if (fl[2])      begin trap = 1; cause = 32'h8000_000B; end
                else if (fl[1]) begin trap = 1; cause = 32'h8000_0003; end
                else if (fl[0]) begin trap = 1; cause = 32'h8000_0007; end
            end
        end
        if (trap) begin
            e.e_mepc   = pc;
            e.e_mcause = cause;
            e.e_mtval  = fl[6] ? inst : 32'h0;
            e.e_ms     = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0);
            e.e_jc     = 5;
            e.e_ja     = (tvec == 0) ? RV : (tvec & ~32'h3);
            e.e_hold   = 6;
        end else if (ret) begin
            e.e_ms   = (ms & ~32'h88) | 32'h80 | (ms[7] ? 32'h8 : 32'h0);
            e.e_jc   = 2;
            e.e_ja   = epc;
            e.e_hold = 3;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] fl, input logic [31:0] pc,
                         input logic [31:0] inst);
        inst_valid_i = v;
        pc_i = pc;
        inst_i = inst;
        {illegal_i, ebreak_i, ecall_i, mret_i, ex_trap_i, soft_trap_i, tcmp_trap_i} = fl;
    endtask

    task automatic load_csrs(input logic [31:0] ms, input logic [31:0] tvec,
                             input logic [31:0] epc, input logic [31:0] mc,
                             input logic [31:0] mt);
        ld_ms = ms; ld_tvec = tvec; ld_epc = epc; ld_mc = mc; ld_mt = mt;
        ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Entered and left at posedge+1; cycle 0 presents the event.
    task automatic run_event(input logic v, input logic [6:0] fl, input logic [31:0] pc,
                             input logic [31:0] inst, input int ncyc, input int col_start,
                             input int col_len, output int hold_cnt, output int jc,
                             output logic [31:0] ja, output int col_viol);
        hold_cnt = 0; jc = -1; ja = 32'h0; col_viol = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) drive(v, fl, pc, inst);
            else        drive(1'b0, 7'b0, 32'h0, 32'h0);
            idex_csr_we_i = (c >= col_start) && (c < col_start + col_len);
            @(negedge clk);
            if (hold_o) hold_cnt++;
            if (idex_csr_we_i && trap_csr_we_o) col_viol++;
            if (jump_o && jc < 0) begin
                jc = c;
                ja = jump_addr_o;
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 7'b0, 32'h0, 32'h0);
        idex_csr_we_i = 1'b0;
    endtask

    task automatic chk_result(input string tag, input vec_t e, input int hold_cnt,
                              input int jc, input logic [31:0] ja);
        chk({tag, "_jcyc"},  32'(jc),       32'(e.e_jc));
        chk({tag, "_jaddr"}, ja,            e.e_ja);
        chk({tag, "_hold"},  32'(hold_cnt), 32'(e.e_hold));
        chk({tag, "_mepc"},  csr_mepc,      e.e_mepc);
        chk({tag, "_mcause"}, csr_mcause,   e.e_mcause);
        chk({tag, "_mtval"}, csr_mtval,     e.e_mtval);
        chk({tag, "_mstat"}, csr_mstatus,   e.e_ms);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ctl"},   {29'h0, trap_csr_we_o, hold_o, jump_o}, 32'h0);
        chk({tag, "_addr"},  {20'h0, trap_csr_addr_o}, 32'h0);
        chk({tag, "_wdata"}, trap_csr_wdata_o, 32'h0);
        chk({tag, "_jaddr"}, jump_addr_o, 32'h0);
    endtask

    vec_t vt[11];

    initial begin
        int          hc, jc, cv;
        logic [31:0] ja;
        vec_t        e;

        vt[0]  = mkv(1, F_ECL, 32'h100, 32'h73, 32'h8, 32'h200, 32'h0,
                     32'h100, 32'd11, 32'h0, 32'h80, 5, 32'h200, 6);
        vt[1]  = mkv(1, F_ILL, 32'h44, 32'hFFFF_FFFF, 32'h0, 32'h200, 32'h0,
                     32'h44, 32'd2, 32'hFFFF_FFFF, 32'h0, 5, 32'h200, 6);
        vt[2]  = mkv(1, F_EXT | F_SFT | F_TMR, 32'h80, 32'h13, 32'h8, 32'h303, 32'h0,
                     32'h80, 32'h8000_000B, 32'h0, 32'h80, 5, 32'h300, 6);
        vt[3]  = mkv(1, F_EXT | F_SFT | F_TMR, 32'h80, 32'h13, 32'h0, 32'h303, 32'h10,
                     32'h10, SC, ST, 32'h0, -1, 32'h0, 0);
        vt[4]  = mkv(1, F_ECL | F_EXT, 32'h60, 32'h73, 32'h8, 32'h200, 32'h0,
                     32'h60, 32'd11, 32'h0, 32'h80, 5, 32'h200, 6);
        vt[5]  = mkv(1, F_MRT, 32'h90, 32'h3020_0073, 32'h80, 32'h200, 32'h3C,
                     32'h3C, SC, ST, 32'h88, 2, 32'h3C, 3);
        vt[6]  = mkv(1, F_EBR | F_ECL, 32'h8, 32'h0010_0073, 32'h1808, 32'h0, 32'h0,
                     32'h8, 32'd3, 32'h0, 32'h1880, 5, RV, 6);
        vt[7]  = mkv(1, F_SFT | F_TMR, 32'h200, 32'h13, 32'h8, 32'h104, 32'h0,
                     32'h200, 32'h8000_0003, 32'h0, 32'h80, 5, 32'h104, 6);
        vt[8]  = mkv(1, F_TMR, 32'h204, 32'h13, 32'h88, 32'h104, 32'h0,
                     32'h204, 32'h8000_0007, 32'h0, 32'h80, 5, 32'h104, 6);
        vt[9]  = mkv(0, F_ECL, 32'h300, 32'h73, 32'h8, 32'h200, 32'h20,
                     32'h20, SC, ST, 32'h8, -1, 32'h0, 0);
        vt[10] = mkv(1, F_ILL | F_EBR | F_ECL | F_MRT | F_EXT, 32'h400, 32'h1234_5678,
                     32'h8, 32'h1000, 32'h0,
                     32'h400, 32'd2, 32'h1234_5678, 32'h80, 5, 32'h1000, 6);

        rst = 1'b1;
        idex_csr_we_i = 1'b0;
        drive(1'b0, 7'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1;

        foreach (vt[i]) begin
            load_csrs(vt[i].ms0, vt[i].tvec0, vt[i].epc0, SC, ST);
            run_event(vt[i].v, vt[i].fl, vt[i].pc, vt[i].inst, 8, 0, 0, hc, jc, ja, cv);
            chk_result($sformatf("vec%0d", i), vt[i], hc, jc, ja);
        end

        // Exception beats a pending interrupt; the interrupt lands after mret.
        load_csrs(32'h8, 32'h200, 32'h0, SC, ST);
        run_event(1, F_ECL | F_EXT, 32'h60, 32'h73, 8, 0, 0, hc, jc, ja, cv);
        chk("pend_first_cause", csr_mcause, 32'd11);
        run_event(1, F_EXT, 32'h64, 32'h13, 8, 0, 0, hc, jc, ja, cv);
        chk("pend_masked_jc", 32'(jc), 32'hFFFF_FFFF);
        chk("pend_masked_hold", 32'(hc), 32'h0);
        run_event(1, F_MRT, 32'h300, 32'h3020_0073, 8, 0, 0, hc, jc, ja, cv);
        chk("pend_mret_ms", csr_mstatus, 32'h88);
        chk("pend_mret_ja", ja, 32'h60);
        run_event(1, F_EXT, 32'h64, 32'h13, 8, 0, 0, hc, jc, ja, cv);
        chk("pend_irq_cause", csr_mcause, 32'h8000_000B);
        chk("pend_irq_mepc", csr_mepc, 32'h64);
        chk("pend_irq_jc", 32'(jc), 32'd5);

        // Collision stall during T_MCAUSE for two cycles.
        load_csrs(32'h8, 32'h200, 32'h0, SC, ST);
        run_event(1, F_ECL, 32'h140, 32'h73, 10, 2, 2, hc, jc, ja, cv);
        chk("col_viol", 32'(cv), 32'h0);
        chk("col_jc", 32'(jc), 32'd7);
        chk("col_hold", 32'(hc), 32'd8);
        chk("col_mcause", csr_mcause, 32'd11);
        chk("col_mepc", csr_mepc, 32'h140);
        chk("col_ms", csr_mstatus, 32'h80);

        // Back-to-back: a new event presented the cycle after jump_o.
        load_csrs(32'h8, 32'h200, 32'h0, SC, ST);
        run_event(1, F_ECL, 32'h180, 32'h73, 6, 0, 0, hc, jc, ja, cv);
        chk("b2b_first_jc", 32'(jc), 32'd5);
        run_event(1, F_ILL, 32'h184, 32'hDEAD_BEEF, 8, 0, 0, hc, jc, ja, cv);
        chk("b2b_jc", 32'(jc), 32'd5);
        chk("b2b_hold", 32'(hc), 32'd6);
        chk("b2b_mcause", csr_mcause, 32'd2);
        chk("b2b_mtval", csr_mtval, 32'hDEAD_BEEF);
        chk("b2b_mepc", csr_mepc, 32'h184);
        chk("b2b_ms", csr_mstatus, 32'h0);

        // Reset pulsed while the sequence sits in T_MCAUSE.
        load_csrs(32'h8, 32'h200, 32'h999, SC, ST);
        drive(1, F_ECL, 32'h120, 32'h73);
        @(posedge clk); #1;
        drive(1'b0, 7'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_we", {31'h0, trap_csr_we_o}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("rst_after");
        @(posedge clk); #1;
        run_event(0, 7'b0, 32'h0, 32'h0, 4, 0, 0, hc, jc, ja, cv);
        chk("rst_no_jump", 32'(jc), 32'hFFFF_FFFF);
        chk("rst_no_hold", 32'(hc), 32'h0);
        chk("rst_mepc", csr_mepc, 32'h120);
        chk("rst_mcause", csr_mcause, SC);
        chk("rst_mtval", csr_mtval, ST);
        chk("rst_ms", csr_mstatus, 32'h8);
        run_event(1, F_ECL, 32'h124, 32'h73, 8, 0, 0, hc, jc, ja, cv);
        e = model(1, F_ECL, 32'h124, 32'h73, 32'h8, 32'h200, 32'h120);
        e.e_mcause = 32'd11;
        chk_result("rst_fresh", e, hc, jc, ja);

        // Randomized events against the reference model.
        for (int n = 0; n < 80; n++) begin
            logic        v;
            logic [6:0]  fl;
            logic [31:0] pc, inst, ms, tvec, epc;
            v    = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < 7; b++) fl[b] = ($urandom_range(0, 3) == 0);
            pc   = $urandom;
            inst = $urandom;
            ms   = $urandom;
            tvec = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            epc  = $urandom;
            load_csrs(ms, tvec, epc, SC, ST);
            run_event(v, fl, pc, inst, 8, 0, 0, hc, jc, ja, cv);
            e = model(v, fl, pc, inst, ms, tvec, epc);
            chk_result($sformatf("rnd%0d", n), e, hc, jc, ja);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
